// File: rtl/pb_gesture_decoder.sv
// Push-button gesture decoder: turns debounced press/release pulses into short, double,
// long and auto-repeat events, and steps a wrapping processing-mode register from them.
module pb_gesture_decoder #(
   parameter int LONG_DELAY    = 50_000_000,
   parameter int DOUBLE_WINDOW = 25_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int NUM_MODES     = 4,
   parameter int MODE_WIDTH    = $clog2(NUM_MODES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  PB_pressed_pulse,
   input  logic                  PB_released_pulse,
   output logic                  short_pulse,
   output logic                  double_pulse,
   output logic                  long_pulse,
   output logic                  repeat_pulse,
   output logic [MODE_WIDTH-1:0] mode,
   output logic                  mode_changed
);

   localparam int MAX_LD_DW = (LONG_DELAY > DOUBLE_WINDOW) ? LONG_DELAY : DOUBLE_WINDOW;
   localparam int MAX_T     = (MAX_LD_DW > REPEAT_PERIOD) ? MAX_LD_DW : REPEAT_PERIOD;
   localparam int TW        = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [TW-1:0]         LONG_TC   = TW'(LONG_DELAY - 1);
   localparam logic [TW-1:0]         DOUBLE_TC = TW'(DOUBLE_WINDOW - 1);
   localparam logic [TW-1:0]         REPEAT_TC = TW'(REPEAT_PERIOD - 1);
   localparam logic [MODE_WIDTH-1:0] MODE_MAX  = MODE_WIDTH'(NUM_MODES - 1);

   typedef enum logic [2:0] {
      IDLE,
      HELD,
      LONG_HELD,
      WAIT_SECOND,
      SECOND_HELD
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         timer        <= '0;
         short_pulse  <= 1'b0;
         double_pulse <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;
         mode         <= '0;
         mode_changed <= 1'b0;
      end else begin
         short_pulse  <= 1'b0;
         double_pulse <= 1'b0;
         long_pulse   <= 1'b0;
         repeat_pulse <= 1'b0;

         case (state)
            IDLE: begin
               timer <= '0;
               if (PB_pressed_pulse) state <= HELD;
            end
            // Release on the terminal-count cycle keeps the gesture on the short path.
            HELD: begin
               if (PB_released_pulse) begin
                  state <= WAIT_SECOND;
                  timer <= '0;
               end else if (timer == LONG_TC) begin
                  long_pulse <= 1'b1;
                  state      <= LONG_HELD;
                  timer      <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            LONG_HELD: begin
               if (PB_released_pulse) begin
                  state <= IDLE;
                  timer <= '0;
               end else if (timer == REPEAT_TC) begin
                  repeat_pulse <= 1'b1;
                  timer        <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT_SECOND: begin
               if (PB_pressed_pulse) begin
                  state <= SECOND_HELD;
                  timer <= '0;
               end else if (timer == DOUBLE_TC) begin
                  short_pulse <= 1'b1;
                  state       <= IDLE;
                  timer       <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            // No terminal count here, so the timer saturates rather than wrapping.
            SECOND_HELD: begin
               if (PB_released_pulse) begin
                  double_pulse <= 1'b1;
                  state        <= IDLE;
                  timer        <= '0;
               end else if (timer != '1) begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase

         // Mode follows the registered event pulses by one cycle.
         mode_changed <= short_pulse | double_pulse | long_pulse | repeat_pulse;
         if (long_pulse) begin
            mode <= '0;
         end else if (short_pulse || repeat_pulse) begin
            mode <= (mode == MODE_MAX) ? '0 : mode + 1'b1;
         end else if (double_pulse) begin
            mode <= (mode == '0) ? MODE_MAX : mode - 1'b1;
         end
      end
   end

endmodule

// File: doc/pb_gesture_decoder.md
PB_GESTURE_DECODER -- requirements
Module: pb_gesture_decoder

Interface
REQ-001 SHALL have parameter LONG_DELAY, default 50_000_000, meaning press-hold cycles to declare a long press.
REQ-002 SHALL have parameter DOUBLE_WINDOW, default 25_000_000, meaning the maximum number of cycles after release to accept a second press.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10_000_000, meaning the number of cycles between auto-repeat pulses after a long press.
REQ-004 SHALL have parameter NUM_MODES, default 4, meaning the number of selectable processing modes (2..256).
REQ-005 SHALL have parameter MODE_WIDTH, default $clog2(NUM_MODES), meaning the width of the mode output.
REQ-006 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port PB_pressed_pulse, input, 1: a one-cycle pulse from the upstream debouncer when the button is pressed.
REQ-009 SHALL have port PB_released_pulse, input, 1: a one-cycle pulse from the upstream debouncer when the button is released.
REQ-010 SHALL have port short_pulse, output, 1: one-cycle pulse marking a single short press.
REQ-011 SHALL have port double_pulse, output, 1: one-cycle pulse marking a double press.
REQ-012 SHALL have port long_pulse, output, 1: one-cycle pulse at long-press detection.
REQ-013 SHALL have port repeat_pulse, output, 1: one-cycle pulse every REPEAT_PERIOD cycles while long-held.
REQ-014 SHALL have port mode, output, MODE_WIDTH: the currently selected processing mode.
REQ-015 SHALL have port mode_changed, output, 1: one-cycle pulse in the first cycle the updated mode is visible.

Function
REQ-016 SHALL implement FSM states IDLE, HELD, LONG_HELD, WAIT_SECOND, SECOND_HELD, with one shared timer cleared on every state entry and incrementing each cycle otherwise.
REQ-017 SHALL transition IDLE->HELD on PB_pressed_pulse and ignore PB_released_pulse in IDLE.
REQ-018 SHALL, in HELD, go to WAIT_SECOND on PB_released_pulse; else, at timer==LONG_DELAY-1, go to LONG_HELD and register long_pulse; release in that same cycle wins (short path).
REQ-019 SHALL, in LONG_HELD, register repeat_pulse and wrap the timer to 0 at timer==REPEAT_PERIOD-1; on PB_released_pulse go to IDLE with no pulse, and release takes priority over repeat.
REQ-020 SHALL, in WAIT_SECOND, go to SECOND_HELD on PB_pressed_pulse; else, at timer==DOUBLE_WINDOW-1, register short_pulse and go to IDLE; press in that same cycle wins.
REQ-021 SHALL, in SECOND_HELD, register double_pulse and go to IDLE on PB_released_pulse; no long detection applies in SECOND_HELD.
REQ-022 SHALL ignore PB_pressed_pulse in HELD, LONG_HELD and SECOND_HELD, and ignore PB_released_pulse in IDLE and WAIT_SECOND.
REQ-023 SHALL assert every event pulse for exactly one cycle, in the cycle after the triggering input or terminal count.
REQ-024 SHALL update mode one cycle after the event pulse, with mode_changed high in that same cycle.
REQ-025 SHALL update mode as follows: short_pulse or repeat_pulse gives mode+1, wrapping NUM_MODES-1->0; double_pulse gives mode-1, wrapping 0->NUM_MODES-1; long_pulse gives 0.
REQ-026 SHALL assert mode_changed on every mode update event, even when the value is unchanged (long press at mode 0).
REQ-027 SHALL size the timer to $clog2 of the largest of LONG_DELAY, DOUBLE_WINDOW and REPEAT_PERIOD, with no overflow in any state.

Reset
REQ-028 SHALL, with rst high, force state IDLE, timer 0, mode 0, and all pulse outputs 0 at the next edge, overriding any in-progress gesture.
REQ-029 SHALL, after rst deasserts, ignore any gesture begun before reset and accept a PB_pressed_pulse in the first cycle after reset.

Verification (LONG_DELAY=8, DOUBLE_WINDOW=6, REPEAT_PERIOD=4, NUM_MODES=4)
REQ-030 SHALL cover: press at cycle 0, release at cycle 3, no further press -> short_pulse at cycle 10 only; mode 0->1 at cycle 11 with mode_changed.
REQ-031 SHALL cover: press at cycle 0, release at cycle 2, press at cycle 5, release at cycle 7 -> double_pulse at cycle 8, no short_pulse; mode 0->3 at cycle 9.
REQ-032 SHALL cover: mode=2, press at cycle 0, held until release at cycle 20 -> long_pulse at cycle 9, mode 0 at cycle 10, repeat_pulse at cycles 13 and 17, mode 1 then 2, no pulse at release.
REQ-033 SHALL cover: press at cycle 0, release at cycle 8 (same cycle as the terminal count) -> no long_pulse; short_pulse follows 6 cycles later.
REQ-034 SHALL cover: four consecutive short presses from mode 0 -> modes 1, 2, 3, 0 (wrap).
REQ-035 SHALL cover: rst asserted during WAIT_SECOND -> no short_pulse, mode 0; a press 1 cycle after reset is accepted.
